rll_key_loader: RTL

Serial key loader for RLL-locked netlists. It accepts a key as a serial bit stream with a trailing even-parity bit and holds it in a shadow register. On a parity match it commits the key to a parallel bus that drives the locked circuit's `keyIn_0_*` inputs, where bit i drives `keyIn_0_i`. It is the writer side of the key interface the locked benchmarks read, and sits between the test/provisioning port and the locked core.

---
 rtl/rll_key_loader.sv | 114 +++++++++++
 1 files changed

// File: rtl/rll_key_loader.sv
// Serial key loader: shifts in KEY_WIDTH bits LSB-first plus an even-parity bit,
// then commits the shadow register to the parallel key bus on a parity match.
module rll_key_loader #(
  parameter int unsigned KEY_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 bit_ready,
  input  logic                 zeroize,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_ready,
  output logic                 load_done,
  output logic                 load_err
);

  localparam int unsigned CNT_W = $clog2(KEY_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [KEY_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic                 key_ready_q, key_ready_d;
  logic                 load_done_q, load_done_d;
  logic                 load_err_q, load_err_d;
  logic                 accept;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      key_q       <= '0;
      key_ready_q <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      key_ready_q <= key_ready_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  // Next-state: zeroize beats load_start, which beats any bit in the same cycle
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    key_ready_d = key_ready_q;
    load_done_d = 1'b0;
    load_err_d  = load_err_q;
    bit_ready   = (state_q == SHIFT) || (state_q == PARITY);
    accept      = bit_valid && bit_ready;

    if (zeroize) begin
      state_d     = IDLE;
      shift_d     = '0;
      cnt_d       = '0;
      key_d       = '0;
      key_ready_d = 1'b0;
      load_err_d  = 1'b0;
    end else if (load_start) begin
      state_d    = SHIFT;
      shift_d    = '0;
      cnt_d      = '0;
      load_err_d = 1'b0;
    end else begin
      unique case (state_q)
        SHIFT: begin
          if (accept) begin
            shift_d = {bit_in, shift_q[KEY_WIDTH-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(KEY_WIDTH - 1)) begin
              state_d = PARITY;
            end
          end
        end
        PARITY: begin
          if (accept) begin
            state_d = IDLE;
            if (bit_in == ^shift_q) begin
              key_d       = shift_q;
              key_ready_d = 1'b1;
              load_done_d = 1'b1;
            end else begin
              load_err_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign key_out   = key_q;
  assign key_ready = key_ready_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule
